ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one synchronous single-port RAM between two requesters (A and B).
// A combinational round-robin arbiter grants at most one request per cycle.
// A two-stage tag pipeline follows each accepted read through the RAM's
// one-cycle read latency. The read data is then returned to the owning port.
//
// Handshake: a request is accepted on a rising edge where x_req_valid and
// x_req_ready are both high. x_req_ready is a combinational function of the
// two valids and the round-robin pointer, and it never depends on ready.
// A requester may hold valid high for as long as it likes. Responses are a
// single-cycle x_rsp_valid pulse with no backpressure. They return in
// request order, two edges after the accepting edge.
module ram_port_arbiter #(
  parameter  int DATA_WIDTH = 12,
  parameter  int RAM_DEPTH  = 4096,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_data,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,

  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_data,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data,

  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // Round-robin pointer: remembers which port won the most recent accept.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  last_t last_q;
  last_t last_d;

  logic                  grant_a;
  logic                  grant_b;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Tag pipeline. Stage 1 lines up with the RAM address register, and
  // stage 2 lines up with the RAM's registered read data.
  logic s1_rd;
  logic s1_owner_b;
  logic s2_rd;
  logic s2_owner_b;

  // Arbitration: a single requester always wins. On contention the port
  // that did not win last time is granted. Nothing is granted during reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_req_valid && b_req_valid) begin
        if (last_q == LAST_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else if (a_req_valid) begin
        grant_a = 1'b1;
      end else if (b_req_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign accept      = grant_a | grant_b;

  // Request mux: the command of the granted port goes to the RAM stage.
  always_comb begin
    sel_we   = a_req_we;
    sel_addr = a_req_addr;
    sel_data = a_req_data;
    if (grant_b) begin
      sel_we   = b_req_we;
      sel_addr = b_req_addr;
      sel_data = b_req_data;
    end
  end

  // Next pointer: it moves only when a request is accepted.
  always_comb begin
    last_d = last_q;
    if (grant_a) begin
      last_d = LAST_A;
    end else if (grant_b) begin
      last_d = LAST_B;
    end
  end

  // Pointer register. It resets to "B won last" so A wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= LAST_B;
    end else begin
      last_q <= last_d;
    end
  end

  // Stage 1: register the RAM command and the read tag on accept.
  // Idle cycles drop the write strobe but keep address and data stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      s1_rd            <= 1'b0;
      s1_owner_b       <= 1'b0;
    end else begin
      ram_write_enable <= accept & sel_we;
      s1_rd            <= accept & ~sel_we;
      if (accept) begin
        ram_address <= sel_addr;
        ram_data_in <= sel_data;
        s1_owner_b  <= grant_b;
      end
    end
  end

  // Stage 2: the tag advances while the RAM performs its synchronous read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_rd      <= 1'b0;
      s2_owner_b <= 1'b0;
    end else begin
      s2_rd      <= s1_rd;
      s2_owner_b <= s1_owner_b;
    end
  end

  // Response: capture the RAM output for the owning port and pulse its valid.
  // The other port's data register keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_data  <= '0;
    end else begin
      a_rsp_valid <= s2_rd & ~s2_owner_b;
      b_rsp_valid <= s2_rd & s2_owner_b;
      if (s2_rd && !s2_owner_b) begin
        a_rsp_data <= ram_data_out;
      end
      if (s2_rd && s2_owner_b) begin
        b_rsp_data <= ram_data_out;
      end
    end
  end

  // Structural invariants of the arbiter and the response path.
  grant_onehot: assert property (@(posedge clk) disable iff (rst)
    !(a_req_ready && b_req_ready));

  rsp_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(a_rsp_valid && b_rsp_valid));

endmodule
